// File: rtl/stream_word_packer_if.sv
// Word stream from the packer FIFO head to the DMA: 32-bit little-endian word,
// lane byte enables and an end-of-flush marker, under a valid/ready handshake.
interface stream_word_packer_if;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_byte_en;
  logic        m_last;
  logic        m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_byte_en,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_byte_en,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/stream_word_packer.sv
// Packs the INT8 pooling output stream into little-endian 32-bit words and queues
// them in a first-word-fall-through FIFO; upstream is never stalled, overflow drops.
module stream_word_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             valid_in,
  input  logic [7:0]                       data_in,
  input  logic                             flush,
  input  logic                             clear_overflow,
  stream_word_packer_if.master             m_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 37;

  logic [1:0]    laneIdx_q, laneIdx_d;
  logic [31:0]   packData_q, packData_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic [31:0]   byteShifted;
  logic [31:0]   writeData;
  logic [2:0]    filledCount;
  logic [3:0]    pushBe;
  logic          closeFull;
  logic          push;
  logic          pop;
  logic          full;
  logic          notEmpty;
  logic          accept;
  logic          drop;
  logic [EW-1:0] pushEntry;
  logic [EW-1:0] headEntry;

  // Lanes above the current index are always zero, so OR-ing the new byte in is safe.
  always_comb begin
    byteShifted = {24'd0, data_in} << {laneIdx_q, 3'b000};
    writeData   = valid_in ? (packData_q | byteShifted) : packData_q;
    filledCount = {1'b0, laneIdx_q} + {2'b00, valid_in};
    closeFull   = valid_in && (laneIdx_q == 2'd3);
    push        = closeFull || flush;
    case (filledCount)
      3'd0:    pushBe = 4'h0;
      3'd1:    pushBe = 4'h1;
      3'd2:    pushBe = 4'h3;
      3'd3:    pushBe = 4'h7;
      default: pushBe = 4'hF;
    endcase
    pushEntry = {flush, pushBe, writeData};
  end

  always_comb begin
    notEmpty = (count_q != '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = notEmpty && m_if.m_ready;
    accept   = push && (!full || pop);
    drop     = push && full && !pop;
  end

  always_comb begin
    laneIdx_d  = laneIdx_q;
    packData_d = packData_q;
    if (push) begin
      laneIdx_d  = 2'd0;
      packData_d = '0;
    end else if (valid_in) begin
      laneIdx_d  = laneIdx_q + 2'd1;
      packData_d = writeData;
    end

    wrPtr_d = accept ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = pop    ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d = count_q + CW'(accept) - CW'(pop);

    // A drop in the same cycle as a clear must leave the flag set.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      laneIdx_q  <= 2'd0;
      packData_q <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      laneIdx_q  <= laneIdx_d;
      packData_q <= packData_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wrPtr_q] <= pushEntry;
    end
  end

  // Head fields are gated by valid so stale or uninitialised storage never leaks out.
  always_comb begin
    headEntry        = mem[rdPtr_q];
    m_if.m_valid     = notEmpty;
    m_if.m_data      = notEmpty ? headEntry[31:0]  : 32'd0;
    m_if.m_byte_en   = notEmpty ? headEntry[35:32] : 4'h0;
    m_if.m_last      = notEmpty && headEntry[36];
    fifo_count       = count_q;
    overflow         = overflow_q;
  end

endmodule

// File: tb/tb_stream_word_packer.sv
// Directed bench for stream_word_packer: packing, flush corner cases, overflow,
// full-FIFO push with pop, and asynchronous mid-word reset.
module tb_stream_word_packer;

  logic       clk;
  logic       reset_n;
  logic       valid_in;
  logic [7:0] data_in;
  logic       flush;
  logic       clear_overflow;
  logic [4:0] fifo_count;
  logic       overflow;
  int         errors;
  int         checks;

  stream_word_packer_if dmaIf ();

  stream_word_packer #(.FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .m_if           (dmaIf),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge and return to idle afterwards.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f,
                               input logic r, input logic clr);
    valid_in       = v;
    data_in        = d;
    flush          = f;
    dmaIf.m_ready  = r;
    clear_overflow = clr;
    @(posedge clk);
    #1;
    valid_in       = 1'b0;
    data_in        = 8'h00;
    flush          = 1'b0;
    dmaIf.m_ready  = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic expValid, input logic [31:0] expData,
                           input logic [3:0] expBe, input logic expLast, input int expCount);
    checkOutput({tag, ".valid"}, {31'd0, dmaIf.m_valid}, {31'd0, expValid});
    checkOutput({tag, ".data"}, dmaIf.m_data, expData);
    checkOutput({tag, ".be"}, {28'd0, dmaIf.m_byte_en}, {28'd0, expBe});
    checkOutput({tag, ".last"}, {31'd0, dmaIf.m_last}, {31'd0, expLast});
    checkOutput({tag, ".count"}, {27'd0, fifo_count}, 32'(expCount));
  endtask

  function automatic logic [31:0] seqWord(input int base);
    return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
  endfunction

  initial begin
    errors         = 0;
    checks         = 0;
    reset_n        = 1'b0;
    valid_in       = 1'b0;
    data_in        = 8'h00;
    flush          = 1'b0;
    clear_overflow = 1'b0;
    dmaIf.m_ready  = 1'b0;
    $display("[TB] start");

    repeat (2) @(posedge clk);
    #1;
    checkHead("reset", 1'b0, 32'h0, 4'h0, 1'b0, 0);
    checkOutput("reset.overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;

    // Full word with ready held high: visible the cycle after the 4th byte.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    checkOutput("pack.notyet", {31'd0, dmaIf.m_valid}, 32'd0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    checkHead("pack", 1'b1, 32'h44332211, 4'hF, 1'b0, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkHead("pack.popped", 1'b0, 32'h0, 4'h0, 1'b0, 0);

    // Six bytes then a standalone flush.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 4) checkOutput("partial.count4", {27'd0, fifo_count}, 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkHead("partial.w0", 1'b1, 32'h04030201, 4'hF, 1'b0, 2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkHead("partial.w1", 1'b1, 32'h00000605, 4'h3, 1'b1, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("partial.empty", {27'd0, fifo_count}, 32'd0);

    // Flush coinciding with the lane-3 byte yields one word, not two.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 1'b0);
    checkHead("flush4", 1'b1, 32'hDDCCBBAA, 4'hF, 1'b1, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkHead("flushEmpty", 1'b1, 32'h0, 4'h0, 1'b1, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkHead("flushEmpty.popped", 1'b0, 32'h0, 4'h0, 1'b0, 0);

    // 17 words into a 16-deep FIFO with no ready: the last one is dropped.
    for (int i = 0; i < 68; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("ovf.count", {27'd0, fifo_count}, 32'd16);
    checkOutput("ovf.flag", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      checkHead($sformatf("ovf.drain%0d", k), 1'b1, seqWord(4 * k), 4'hF, 1'b0, 16 - k);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checkHead("ovf.drained", 1'b0, 32'h0, 4'h0, 1'b0, 0);
    checkOutput("ovf.sticky", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf.cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO: a pop in the closing cycle makes room for the new word.
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("fullPop.full", {27'd0, fifo_count}, 32'd16);
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    checkOutput("fullPop.count", {27'd0, fifo_count}, 32'd16);
    checkOutput("fullPop.overflow", {31'd0, overflow}, 32'd0);
    for (int k = 1; k < 16; k++) begin
      checkHead($sformatf("fullPop.drain%0d", k), 1'b1, seqWord(8'h80 + 4 * k), 4'hF, 1'b0, 17 - k);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checkHead("fullPop.newest", 1'b1, 32'hC3C2C1C0, 4'hF, 1'b0, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("fullPop.empty", {27'd0, fifo_count}, 32'd0);

    // Asynchronous reset mid-word with a word queued; outputs clear before any edge.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    checkOutput("midReset.before", {27'd0, fifo_count}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkHead("midReset.async", 1'b0, 32'h0, 4'h0, 1'b0, 0);
    checkOutput("midReset.overflow", {31'd0, overflow}, 32'd0);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checkHead("midReset.after", 1'b1, 32'h04030201, 4'hF, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
